// File: rtl/lab_shift_pkg.sv
// Shared encodings for the universal shift register: operating modes and
// burst-controller states.
package lab_shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic logic is_shift_mode(input logic [1:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR);
    endfunction

endpackage

// File: rtl/lab_shift_step.sv
// One-step next-value mux for the shift register: hold, shift left/right
// (rotate or serial fill) or parallel load. Purely combinational.
module lab_shift_step
    import lab_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [1:0]       mode_i,
    input  logic             rot_i,
    input  logic             sin_l_i,
    input  logic             sin_r_i,
    output logic [WIDTH-1:0] q_next_o
);

    always_comb begin
        q_next_o = q_i;
        case (mode_i)
            MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], rot_i ? q_i[WIDTH-1] : sin_r_i};
            MODE_SHR:  q_next_o = {rot_i ? q_i[0] : sin_l_i, q_i[WIDTH-1:1]};
            MODE_LOAD: q_next_o = d_i;
            default:   q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/lab_universal_shift_reg.sv
// Universal shift register with single-step operations and an n-step shift
// burst controller (IDLE -> BURST -> DONE) that exposes its state on dbg_state.
module lab_universal_shift_reg
    import lab_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] D,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             rot_q, rot_d;

    logic [1:0]       step_mode;
    logic             step_rot;
    logic [WIDTH-1:0] step_q;

    // A running burst uses the mode/rot captured at start; serial inputs stay live.
    assign step_mode = (state_q == ST_BURST) ? mode_q : mode;
    assign step_rot  = (state_q == ST_BURST) ? rot_q  : rot;

    lab_shift_step #(.WIDTH(WIDTH)) u_step (
        .q_i      (q_q),
        .d_i      (D),
        .mode_i   (step_mode),
        .rot_i    (step_rot),
        .sin_l_i  (sin_l),
        .sin_r_i  (sin_r),
        .q_next_o (step_q)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        rot_d   = rot_q;
        case (state_q)
            ST_IDLE: begin
                if (E) begin
                    if (start) begin
                        if (is_shift_mode(mode) && (n != '0)) begin
                            q_d     = step_q;
                            mode_d  = mode;
                            rot_d   = rot;
                            cnt_d   = n - CNT_W'(1);
                            state_d = (n != CNT_W'(1)) ? ST_BURST : ST_DONE;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        q_d = step_q;
                    end
                end
            end
            ST_BURST: begin
                // cnt_q counts shifts still owed; the last one lands us in DONE.
                if (E) begin
                    q_d   = step_q;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            rot_q   <= rot_d;
        end
    end

    assign Q         = q_q;
    assign Qb        = ~q_q;
    assign busy      = (state_q == ST_BURST);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule
